seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Iterative radix-2 restoring divider: the responder side of the execute-stage divide handshake.
//  Execute drives sourceData/sign/A/B and stalls on (hasData & !dataOK).
//  This block returns {quotient, remainder} with a one-cycle dataOK strobe; the result is written to HI/LO.
//  Latency is fixed at WIDTH+2 cycles.
// PARAMETERS
//  WIDTH   32   operand width; quotient and remainder are each WIDTH bits
// PORTS
//  clk         in   1         clock, all state updates on rising edge
//  rst         in   1         synchronous reset, active-high
//  flush       in   1         pipeline flush (exception); aborts in-flight divide
//  sourceData  in   1         divide request (level; held by execute while stalled)
//  sign        in   1         1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept
//  A           in   WIDTH     dividend, sampled at accept
//  B           in   WIDTH     divisor, sampled at accept
//  F           out  2*WIDTH   {quotient[2W-1:W], remainder[W-1:0]}, registered
//  hasData     out  1         divide in progress (incl. accept and DONE cycles)
//  dataOK      out  1         one-cycle result-valid strobe, registered
// BEHAVIOUR
//  Reset: only one clock and one reset; reset is synchronous and active-high.
//    On rst: state=IDLE, F=0, dataOK=0, hasData=0, and all internal registers are cleared.
//  States:
//    IDLE -> CALC on (sourceData & !flush); flush has priority over a new request.
//    CALC runs WIDTH cycles on a down-counter from WIDTH-1; it moves to FIX when the count is 0.
//    FIX -> DONE. DONE -> IDLE unconditionally.
//  Accept (cycle 0, IDLE & sourceData):
//    Latch sign and magnitudes |A|, |B| (magnitude = two's-complement negate if sign & MSB).
//    Latch negQ = sign & (A[W-1]^B[W-1]) and negR = sign & A[W-1].
//  hasData = (state!=IDLE) | (state==IDLE & sourceData & !flush).
//    This is combinational, so execute stalls from cycle 0; hasData stays 1 through DONE.
//  CALC (cycles 1..WIDTH), one quotient bit per cycle, MSB first:
//    rem' = {rem[W-2:0], dvd[W-1]}, dvd shifts left.
//    If rem' >= |B| (W+1-bit compare), then rem = rem' - |B| and qbit = 1; else qbit = 0.
//  FIX (cycle WIDTH+1): Q = negQ ? -q : q and R = negR ? -r : r.
//    Results wrap mod 2^W, with no overflow flag.
//  DONE (cycle WIDTH+2):
//    F <= {Q, R} at entry to DONE; dataOK=1 for exactly this cycle.
//    F holds its value until the next DONE or rst.
//  sourceData seen in DONE is ignored; it is the still-held old request.
//    A new request is accepted only in IDLE, so the earliest back-to-back accept is the cycle after DONE.
//  Divide by zero (B==0, either sign): F = {{WIDTH{1'b1}}, A}, i.e. quotient all-ones and remainder equal to raw A.
//    Latency is the same; this is produced in FIX, overriding sign correction.
//  Signed -2^(W-1) / -1: Q = 2^(W-1) (0x8000_0000), R = 0; wraps silently.
//  flush in CALC/FIX: next state is IDLE, dataOK never asserts, F is unchanged, and hasData drops the next cycle.
//    flush in DONE: dataOK still pulses; the HI/LO write is the consumer's concern.
//  rst mid-operation: same as flush, and additionally F=0.
//  A, B and sign changing after accept have no effect.
// TESTING
//  1. DIVU A=100, B=7 accepted at cycle 0 -> dataOK=1 only at cycle 34, F={32'd14, 32'd2}; hasData 1 on cycles 0..34, 0 at 35.
//  2. DIV A=-7 (FFFFFFF9), B=2 -> F={FFFFFFFD, FFFFFFFF}; DIV A=7, B=-2 -> F={FFFFFFFD, 00000001}.
//  3. DIV A=80000000, B=FFFFFFFF -> F={80000000, 00000000}; DIVU A=5, B=0 -> F={FFFFFFFF, 00000005}.
//  4. sourceData held high through DONE, then a new DIVU 9/3 presented at cycle 35 -> no re-accept in DONE;
//     second dataOK at cycle 69 with F={3,0}.
//  5. flush at cycle 10 of a divide -> no dataOK, F retains its prior value, hasData=0 at cycle 11;
//     a request at cycle 11 completes normally.
//  6. rst asserted at cycle 20 mid-divide -> F=0, dataOK=0, hasData=0 next cycle; simultaneous rst+sourceData is not accepted.

Source files
------------

// File: rtl/seq_divider_if.sv
// ---------------------------------------------------------------------------
// seq_divider_if
// Divide handshake between the execute stage (master) and the iterative
// divider (slave).
//   flush       master -> slave  abort any in-flight divide
//   sourceData  master -> slave  divide request, held while execute is stalled
//   sign        master -> slave  1 = signed (DIV), 0 = unsigned (DIVU)
//   A, B        master -> slave  dividend / divisor
//   F           slave -> master  {quotient, remainder}, registered
//   hasData     slave -> master  divide in progress (execute stalls on it)
//   dataOK      slave -> master  one-cycle result-valid strobe
// WIDTH must match the WIDTH of the seq_divider it is connected to.
// ---------------------------------------------------------------------------
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic               flush;
  logic               sourceData;
  logic               sign;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] F;
  logic               hasData;
  logic               dataOK;

  modport master (
    output flush, sourceData, sign, A, B,
    input  F, hasData, dataOK
  );

  modport slave (
    input  flush, sourceData, sign, A, B,
    output F, hasData, dataOK
  );
endinterface

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Iterative radix-2 restoring divider, responder side of the execute-stage
// divide handshake. One quotient bit is produced per cycle, MSB first, on the
// operand magnitudes; signs are applied afterwards in a single fix-up cycle.
// Fixed latency: the result strobe (dataOK) arrives WIDTH+2 cycles after the
// accept cycle.
// Ports:
//   clk   in   clock, all state updates on the rising edge
//   rst   in   synchronous active-high reset; clears every register
//   bus   slave modport of seq_divider_if (flush, sourceData, sign, A, B in;
//         F, hasData, dataOK out)
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  seq_divider_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_reg;
  logic [CW-1:0]      count_reg;
  logic [WIDTH-1:0]   rem_reg;       // partial remainder
  logic [WIDTH-1:0]   dvd_reg;       // dividend shifts out at the top, quotient shifts in at the bottom
  logic [WIDTH-1:0]   divisor_reg;   // |B|
  logic [WIDTH-1:0]   a_raw_reg;     // raw A, returned as remainder on divide by zero
  logic               neg_q_reg;
  logic               neg_r_reg;
  logic               div_zero_reg;
  logic [2*WIDTH-1:0] f_reg;
  logic               data_ok_reg;

  // ------------------------------------------------------------------------
  // Accept / handshake
  // ------------------------------------------------------------------------
  logic accept;
  assign accept = (state_reg == IDLE) && bus.sourceData && !bus.flush;

  // Combinational so that execute stalls in the very cycle it presents the
  // request; held high through DONE.
  assign bus.hasData = (state_reg != IDLE) || accept;
  assign bus.F       = f_reg;
  assign bus.dataOK  = data_ok_reg;

  // Operand magnitudes, only meaningful for signed requests with MSB set.
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  assign a_neg = bus.sign && bus.A[WIDTH-1];
  assign b_neg = bus.sign && bus.B[WIDTH-1];
  assign a_mag = a_neg ? ({WIDTH{1'b0}} - bus.A) : bus.A;
  assign b_mag = b_neg ? ({WIDTH{1'b0}} - bus.B) : bus.B;

  // ------------------------------------------------------------------------
  // One restoring step
  // ------------------------------------------------------------------------
  // The shifted remainder needs WIDTH+1 bits: the remainder is always below
  // the divisor, but after the shift it can exceed 2^WIDTH-1.
  logic [WIDTH:0]   rem_shift;
  logic             q_bit;
  logic [WIDTH-1:0] rem_diff;
  assign rem_shift = {rem_reg, dvd_reg[WIDTH-1]};
  assign q_bit     = rem_shift >= {1'b0, divisor_reg};
  // When q_bit is set the true difference is below the divisor, so the low
  // WIDTH bits of a modular subtract are exact.
  assign rem_diff  = rem_shift[WIDTH-1:0] - divisor_reg;

  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_next;
  assign rem_next = q_bit ? rem_diff : rem_shift[WIDTH-1:0];
  assign dvd_next = {dvd_reg[WIDTH-2:0], q_bit};

  // ------------------------------------------------------------------------
  // Sign fix-up. After CALC, dvd_reg holds |q| and rem_reg holds |r|.
  // Two's-complement negation wraps, so -2^(W-1) / -1 yields 2^(W-1).
  // ------------------------------------------------------------------------
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [2*WIDTH-1:0] f_next;
  assign q_fix  = neg_q_reg ? ({WIDTH{1'b0}} - dvd_reg) : dvd_reg;
  assign r_fix  = neg_r_reg ? ({WIDTH{1'b0}} - rem_reg) : rem_reg;
  // Divide by zero overrides sign correction with a fixed pattern.
  assign f_next = div_zero_reg ? {{WIDTH{1'b1}}, a_raw_reg} : {q_fix, r_fix};

  // ------------------------------------------------------------------------
  // Control FSM and datapath registers
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      rem_reg      <= '0;
      dvd_reg      <= '0;
      divisor_reg  <= '0;
      a_raw_reg    <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      f_reg        <= '0;
      data_ok_reg  <= 1'b0;
    end else begin
      // dataOK is only ever set on the FIX -> DONE transition.
      data_ok_reg <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (accept) begin
            rem_reg      <= '0;
            dvd_reg      <= a_mag;
            divisor_reg  <= b_mag;
            a_raw_reg    <= bus.A;
            neg_q_reg    <= bus.sign && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            neg_r_reg    <= a_neg;
            div_zero_reg <= (bus.B == '0);
            count_reg    <= CW'(WIDTH - 1);
            state_reg    <= CALC;
          end
        end

        CALC: begin
          if (bus.flush) begin
            state_reg <= IDLE;
          end else begin
            rem_reg <= rem_next;
            dvd_reg <= dvd_next;
            if (count_reg == '0) begin
              state_reg <= FIX;
            end else begin
              count_reg <= count_reg - 1'b1;
            end
          end
        end

        FIX: begin
          if (bus.flush) begin
            // Aborted: F keeps the previous result, no strobe.
            state_reg <= IDLE;
          end else begin
            f_reg       <= f_next;
            data_ok_reg <= 1'b1;
            state_reg   <= DONE;
          end
        end

        DONE: begin
          // Any sourceData here is the old, still-held request; never
          // re-accepted from DONE.
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
// Directed bench for seq_divider: hand-computed divide vectors, latency and
// hasData profile, back-to-back request, flush and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request in the current cycle (cycle 0), holds it until the
  // strobe, scrambles the operands after accept, and checks result, latency
  // and hasData. With hold=1 the request stays high after DONE so the caller
  // can present a back-to-back request in the following cycle.
  task automatic do_div(input string tag, input logic sgn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_f, input bit hold);
    int done_cyc;
    bit hd_low;
    done_cyc = -1;
    hd_low   = 1'b0;
    bus.sourceData = 1'b1;
    bus.sign       = sgn;
    bus.A          = a;
    bus.B          = b;
    for (int c = 0; c < 60 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (!bus.hasData) hd_low = 1'b1;
      if (bus.dataOK) begin
        done_cyc = c;
        check_val({tag, " F"}, bus.F, exp_f);
      end
      tick();
      if (c == 0) begin
        bus.A    = $urandom;
        bus.B    = $urandom;
        bus.sign = ~sgn;
      end
    end
    check_val({tag, " latency"}, 64'(done_cyc), 64'd34);
    check_val({tag, " hasData held"}, 64'(hd_low), 64'd0);
    if (!hold) begin
      bus.sourceData = 1'b0;
      @(negedge clk);
      check_val({tag, " hasData after"}, 64'(bus.hasData), 64'd0);
      check_val({tag, " dataOK after"}, 64'(bus.dataOK), 64'd0);
      check_val({tag, " F held"}, bus.F, exp_f);
      tick();
    end
    $display("%s: sign=%0d A=%h B=%h -> F=%h latency=%0d", tag, sgn, a, b, bus.F, done_cyc);
  endtask

  initial begin
    int pulses;
    rst            = 1'b1;
    bus.flush      = 1'b0;
    bus.sourceData = 1'b0;
    bus.sign       = 1'b0;
    bus.A          = '0;
    bus.B          = '0;
    repeat (3) tick();
    check_val("reset F", bus.F, 64'd0);
    check_val("reset dataOK", 64'(bus.dataOK), 64'd0);
    check_val("reset hasData", 64'(bus.hasData), 64'd0);
    rst = 1'b0;
    tick();

    // Flush has priority over a new request in IDLE.
    bus.sourceData = 1'b1;
    bus.flush      = 1'b1;
    bus.A          = 32'd40;
    bus.B          = 32'd4;
    #1;
    check_val("flush blocks accept", 64'(bus.hasData), 64'd0);
    tick();
    check_val("flush blocks accept next", 64'(bus.hasData), 64'd0);
    bus.flush      = 1'b0;
    bus.sourceData = 1'b0;
    tick();

    do_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd14, 32'd2}, 1'b0);
    do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFD, 32'hFFFF_FFFF}, 1'b0);
    do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'hFFFF_FFFD, 32'h0000_0001}, 1'b0);
    do_div("divu big/2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'h7FFF_FFFC, 32'h0000_0001}, 1'b0);
    do_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, 1'b0);
    do_div("divu 5/0", 1'b0, 32'd5, 32'd0, {32'hFFFF_FFFF, 32'h0000_0005}, 1'b0);
    do_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFB}, 1'b0);
    do_div("divu max/16", 1'b0, 32'hFFFF_FFFF, 32'd16, {32'h0FFF_FFFF, 32'h0000_000F}, 1'b0);
    do_div("divu 3/10", 1'b0, 32'd3, 32'd10, {32'd0, 32'd3}, 1'b0);

    // Request held through DONE, new request presented the cycle after.
    do_div("divu 20/6 held", 1'b0, 32'd20, 32'd6, {32'd3, 32'd2}, 1'b1);
    do_div("divu 9/3 back", 1'b0, 32'd9, 32'd3, {32'd3, 32'd0}, 1'b0);

    // Flush at cycle 10 of a divide.
    bus.sourceData = 1'b1;
    bus.sign       = 1'b0;
    bus.A          = 32'd1000;
    bus.B          = 32'd10;
    for (int c = 0; c < 10; c++) tick();
    bus.flush = 1'b1;
    @(negedge clk);
    check_val("flush c10 dataOK", 64'(bus.dataOK), 64'd0);
    tick();
    bus.flush      = 1'b0;
    bus.sourceData = 1'b0;
    #1;
    check_val("flush c11 hasData", 64'(bus.hasData), 64'd0);
    check_val("flush c11 dataOK", 64'(bus.dataOK), 64'd0);
    check_val("flush c11 F kept", bus.F, {32'd3, 32'd0});
    do_div("div -100/7 after flush", 1'b1, 32'hFFFF_FF9C, 32'd7, {32'hFFFF_FFF2, 32'hFFFF_FFFE}, 1'b0);

    // Reset at cycle 20 of a divide.
    bus.sourceData = 1'b1;
    bus.sign       = 1'b0;
    bus.A          = 32'd50;
    bus.B          = 32'd5;
    for (int c = 0; c < 20; c++) tick();
    rst = 1'b1;
    tick();
    bus.sourceData = 1'b0;
    #1;
    check_val("rst F cleared", bus.F, 64'd0);
    check_val("rst dataOK", 64'(bus.dataOK), 64'd0);
    check_val("rst hasData", 64'(bus.hasData), 64'd0);
    tick();
    bus.sourceData = 1'b1;   // request while rst is still high
    tick();
    rst            = 1'b0;
    bus.sourceData = 1'b0;
    #1;
    check_val("rst+req not accepted", 64'(bus.hasData), 64'd0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.dataOK) pulses++;
    end
    check_val("rst+req no strobe", 64'(pulses), 64'd0);
    tick();
    do_div("divu 50/5 after rst", 1'b0, 32'd50, 32'd5, {32'd10, 32'd0}, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
